piso_byte_serializer: RTL and testbench
=======================================

Name: piso_byte_serializer

Overview:
- Parallel-in, serial-out converter: captures a 128-bit word (one AES block) and emits it one byte at a time, most-significant byte first, toward the UART transmit path.
- The downstream consumer paces the output with `hold`. `empty` reports when no bytes remain.
- Sits between the AES core output and the UART TX byte interface.

Parameters:
- DATA_W, 128, parallel input width in bits; must be a multiple of OUT_W.
- OUT_W, 8, serial output word width in bits.
- NUM_WORDS, DATA_W/OUT_W (16), derived; number of output words per load.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture parallel_in on this rising edge.
- hold  input  1  1 = freeze the shifter; 0 = consume the current byte at this edge.
- parallel_in  input  DATA_W  word to serialize; sampled only when load=1.
- serial_out  output  OUT_W  byte currently presented (upper OUT_W bits of the shift register).
- empty  output  1  1 = no unsent bytes remain.

Behaviour:
- State:
  - shift_reg[DATA_W-1:0]
  - remaining-byte counter cnt, range 0..NUM_WORDS (5 bits for the defaults).
- Outputs:
  - serial_out = shift_reg[DATA_W-1 -: OUT_W].
  - empty = (cnt == 0).
  - Both are combinational decodes of the registers, with no extra latency.
- Reset (reset=1 at a rising edge): shift_reg=0 and cnt=0, so serial_out=8'h00 and empty=1. Reset overrides load and hold.
- Priority each edge: reset > load > shift > idle.
- Load (load=1, reset=0):
  - shift_reg <= parallel_in and cnt <= NUM_WORDS, regardless of hold and current cnt.
  - A load while bytes remain discards the unsent bytes (restart).
  - First byte, parallel_in[127:120], is on serial_out and empty=0 the cycle after the load edge.
- Shift (load=0, hold=0, cnt!=0):
  - shift_reg <= shift_reg << OUT_W, zero-filled from the LSB side.
  - cnt <= cnt-1.
  - The byte visible before the edge counts as consumed at that edge.
- Hold (load=0, hold=1): shift_reg and cnt unchanged; serial_out stays stable indefinitely.
- Empty (cnt==0, load=0): no change. hold is don't-care, and the counter must not wrap below 0.
- Full sequence: after a load, exactly NUM_WORDS edges with hold=0 empty the block.
  - empty rises after the 16th consuming edge.
  - serial_out is then 8'h00.
- Timing:
  - No combinational path from any input to any output.
  - Inputs are sampled only at rising edges; glitches between edges are ignored.

Test Plan:
1. Reset: reset=1 for one edge, then 0 -> serial_out=8'h00, empty=1; both hold for 5 idle cycles (load=0).
2. Load under hold:
   - Stimulus: parallel_in=128'hFEDCBA9876543210_FEDCBA9876543210 with load=1 for one edge, hold=1 throughout.
   - Response: next cycle serial_out=8'hFE, empty=0, both unchanged for 10 further cycles.
3. Drain:
   - Stimulus: after scenario 2, hold=0 for 16 edges.
   - Response: the byte before each edge is FE,DC,BA,98,76,54,32,10,FE,DC,BA,98,76,54,32,10. After the 16th edge empty=1 and serial_out=8'h00; extra hold=0 edges change nothing.
4. Mid-stream stall:
   - Stimulus: load the same word, hold=0 for 3 edges, hold=1 for 4 edges, then hold=0.
   - Response: serial_out=8'h98 throughout the stall, empty=0. Draining resumes 98,76,… and empty asserts after 13 more consuming edges.
5. Reload mid-stream:
   - Stimulus: after 5 bytes consumed, load=1 with parallel_in=128'h00112233445566778899AABBCCDDEEFF.
   - Response: next cycle serial_out=8'h00 (the new MSB), empty=0. Exactly 16 consuming edges are then needed to reach empty=1.
6. Reset mid-operation:
   - Stimulus: reset=1 while 7 bytes remain, with hold=0 and load=1 asserted at the same edge.
   - Response: empty=1 and serial_out=8'h00 the next cycle.

Source files
------------

// File: rtl/piso_byte_serializer.sv
// piso_byte_serializer
// Parallel-in, serial-out converter. A DATA_W-bit word (one AES block by
// default) is captured on load and presented OUT_W bits at a time, most
// significant word first, toward the UART transmit byte interface. The
// downstream consumer paces the stream with hold.
//
// Ports:
//   clk          system clock, all state updates on its rising edge
//   reset        synchronous active-high reset, overrides load and hold
//   load         capture parallel_in at this edge (restarts any block in flight)
//   hold         1 = freeze the shifter, 0 = consume the presented byte at this edge
//   parallel_in  word to serialize, sampled only when load=1
//   serial_out   byte currently presented (upper OUT_W bits of the shifter)
//   empty        1 = no unsent bytes remain
//
// Both outputs decode registers only, so no input reaches an output
// combinationally.

module piso_byte_serializer #(
   parameter int DATA_W = 128,
   parameter int OUT_W  = 8,
   localparam int NUM_WORDS = DATA_W / OUT_W,
   localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              hold,
   input  logic [DATA_W-1:0] parallel_in,
   output logic [OUT_W-1:0]  serial_out,
   output logic              empty
);

   logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Next-state selection. Load wins over shifting, so a load while bytes
   // remain simply discards them. Shifting only happens while bytes remain,
   // which keeps the counter from wrapping below zero and leaves the
   // zero-filled shifter untouched once the block has drained.
   always_comb begin
      shiftReg_d = shiftReg_q;
      cnt_d      = cnt_q;
      if (load) begin
         shiftReg_d = parallel_in;
         cnt_d      = CNT_W'(NUM_WORDS);
      end else if (!hold && (cnt_q != '0)) begin
         shiftReg_d = shiftReg_q << OUT_W;
         cnt_d      = cnt_q - CNT_W'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         shiftReg_q <= '0;
         cnt_q      <= '0;
      end else begin
         shiftReg_q <= shiftReg_d;
         cnt_q      <= cnt_d;
      end
   end

   // The presented byte is always the top of the shifter; after the last
   // consuming edge the zero fill makes it read as all zeros.
   assign serial_out = shiftReg_q[DATA_W-1 -: OUT_W];
   assign empty      = (cnt_q == '0);

endmodule

// File: tb/tb_piso_byte_serializer.sv
// Directed testbench for piso_byte_serializer. Each scenario task drives its
// stimulus and checks serial_out/empty 1 time unit after the rising edge.

module tb_piso_byte_serializer;

   logic         clk;
   logic         reset;
   logic         load;
   logic         hold;
   logic [127:0] parallel_in;
   logic [7:0]   serial_out;
   logic         empty;

   int assertCount = 0;
   int failCount   = 0;

   localparam logic [127:0] WORD_A = 128'hFEDCBA9876543210_FEDCBA9876543210;
   localparam logic [127:0] WORD_B = 128'h00112233445566778899AABBCCDDEEFF;

   piso_byte_serializer dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .hold        (hold),
      .parallel_in (parallel_in),
      .serial_out  (serial_out),
      .empty       (empty)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling or re-driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected byte i (0 = most significant) of a 128-bit word.
   function automatic logic [7:0] byteOf(input logic [127:0] w, input int i);
      logic [127:0] t;
      t = w >> (8 * (15 - i));
      return t[7:0];
   endfunction

   // Load a word with the given hold level, returning to load=0 afterwards.
   task automatic applyLoad(input logic [127:0] w, input logic h);
      parallel_in = w;
      load        = 1'b1;
      hold        = h;
      tick();
      load        = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load  = 1'b0;
      hold  = 1'b0;
      parallel_in = '0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         assertCount++;
         if (serial_out !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_serial cycle %0d: got %h expected 00", i, serial_out);
         end
         assertCount++;
         if (empty !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_empty cycle %0d: got %b expected 1", i, empty);
         end
         tick();
      end
   endtask

   task automatic test_load_hold();
      applyLoad(WORD_A, 1'b1);
      for (int i = 0; i < 11; i++) begin
         assertCount++;
         if (serial_out !== 8'hFE) begin
            failCount++;
            $display("[TB] FAIL load_hold_serial cycle %0d: got %h expected FE", i, serial_out);
         end
         assertCount++;
         if (empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL load_hold_empty cycle %0d: got %b expected 0", i, empty);
         end
         tick();
      end
   endtask

   task automatic test_drain();
      hold = 1'b0;
      for (int i = 0; i < 16; i++) begin
         assertCount++;
         if (serial_out !== byteOf(WORD_A, i)) begin
            failCount++;
            $display("[TB] FAIL drain_byte %0d: got %h expected %h", i, serial_out, byteOf(WORD_A, i));
         end
         assertCount++;
         if (empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL drain_empty before edge %0d: got %b expected 0", i, empty);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         assertCount++;
         if (empty !== 1'b1 || serial_out !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL drain_done extra %0d: got empty=%b serial=%h expected empty=1 serial=00", i, empty, serial_out);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      applyLoad(WORD_A, 1'b0);
      hold = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         assertCount++;
         if (serial_out !== 8'h98 || empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall cycle %0d: got serial=%h empty=%b expected serial=98 empty=0", i, serial_out, empty);
         end
         if (i < 4) tick();
      end
      hold = 1'b0;
      for (int i = 3; i < 16; i++) begin
         assertCount++;
         if (serial_out !== byteOf(WORD_A, i) || empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall_resume byte %0d: got serial=%h empty=%b expected serial=%h empty=0", i, serial_out, empty, byteOf(WORD_A, i));
         end
         tick();
      end
      assertCount++;
      if (empty !== 1'b1 || serial_out !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL stall_done: got empty=%b serial=%h expected empty=1 serial=00", empty, serial_out);
      end
   endtask

   task automatic test_reload();
      applyLoad(WORD_A, 1'b0);
      hold = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      assertCount++;
      if (serial_out !== 8'h54) begin
         failCount++;
         $display("[TB] FAIL reload_pre: got %h expected 54", serial_out);
      end
      applyLoad(WORD_B, 1'b0);
      for (int i = 0; i < 16; i++) begin
         assertCount++;
         if (serial_out !== byteOf(WORD_B, i) || empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reload byte %0d: got serial=%h empty=%b expected serial=%h empty=0", i, serial_out, empty, byteOf(WORD_B, i));
         end
         tick();
      end
      assertCount++;
      if (empty !== 1'b1 || serial_out !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL reload_done: got empty=%b serial=%h expected empty=1 serial=00", empty, serial_out);
      end
   endtask

   task automatic test_reset_mid();
      applyLoad(WORD_B, 1'b0);
      hold = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      assertCount++;
      if (serial_out !== 8'h99 || empty !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_mid_pre: got serial=%h empty=%b expected serial=99 empty=0", serial_out, empty);
      end
      reset       = 1'b1;
      load        = 1'b1;
      hold        = 1'b0;
      parallel_in = WORD_A;
      tick();
      reset = 1'b0;
      load  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         assertCount++;
         if (empty !== 1'b1 || serial_out !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_mid cycle %0d: got empty=%b serial=%h expected empty=1 serial=00", i, empty, serial_out);
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b0;
      load  = 1'b0;
      hold  = 1'b0;
      parallel_in = '0;
      #2;
      test_reset();
      test_load_hold();
      test_drain();
      test_stall();
      test_reload();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
